// File: rtl/fifo_pair_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pair_reader
//  Description : Drains a show-ahead FIFO and packs consecutive words into
//                (a, b) operand pairs. Each pair is offered on a valid/ready
//                handshake. Pairs are grouped into frames of FRAME_PAIRS, and
//                the last pair of each frame is marked.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                flush            - synchronous abort of current pair/frame
//                fifo_empty/data  - show-ahead FIFO head (data valid if !empty)
//                fifo_re          - FIFO pop strobe (combinational)
//                out_valid/ready  - pair handshake
//                out_a/out_b      - older / newer word of the pair
//                out_last         - pair is the last of its frame
//                pair_count       - frame index of the pair fetched or held
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_pair_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_PAIRS = 16,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  pair_count
);

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_LAST_IDX = CNT_WIDTH'(FRAME_PAIRS - 1);
    localparam logic [CNT_WIDTH-1:0] c_ONE      = CNT_WIDTH'(1);

    state_t                  r_state_q,  w_state_d;
    logic [DATA_WIDTH-1:0]   r_a_q,      w_a_d;
    logic [DATA_WIDTH-1:0]   r_b_q,      w_b_d;
    logic                    r_valid_q,  w_valid_d;
    logic [CNT_WIDTH-1:0]    r_count_q,  w_count_d;
    logic                    w_fifo_re;

    // Pop strobe. In HOLD a pop only happens together with a handshake, so
    // the next pair's first word is fetched back-to-back. rst_n gates it so
    // nothing is popped while reset is held.
    always_comb begin
        w_fifo_re = 1'b0;
        if (rst_n && !flush && !fifo_empty) begin
            case (r_state_q)
                GET_A, GET_B: w_fifo_re = 1'b1;
                HOLD:         w_fifo_re = out_ready;
                default:      w_fifo_re = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_valid_d = r_valid_q;
        w_count_d = r_count_q;
        if (flush) begin
            // Abandon any partial or held pair; operand registers keep
            // stale contents which are never presented as valid.
            w_state_d = GET_A;
            w_valid_d = 1'b0;
            w_count_d = '0;
        end else begin
            case (r_state_q)
                GET_A: begin
                    if (!fifo_empty) begin
                        w_a_d     = fifo_data;
                        w_state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (!fifo_empty) begin
                        w_b_d     = fifo_data;
                        w_valid_d = 1'b1;
                        w_state_d = HOLD;
                    end
                end
                HOLD: begin
                    // out_valid is always set in HOLD, so out_ready alone
                    // completes the handshake.
                    if (out_ready) begin
                        w_count_d = (r_count_q == c_LAST_IDX) ? '0 : (r_count_q + c_ONE);
                        w_valid_d = 1'b0;
                        if (!fifo_empty) begin
                            w_a_d     = fifo_data;
                            w_state_d = GET_B;
                        end else begin
                            w_state_d = GET_A;
                        end
                    end
                end
                default: begin
                    w_state_d = GET_A;
                    w_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= GET_A;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_valid_q <= 1'b0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_valid_q <= w_valid_d;
            r_count_q <= w_count_d;
        end
    end

    assign fifo_re    = w_fifo_re;
    assign out_valid  = r_valid_q;
    assign out_a      = r_a_q;
    assign out_b      = r_b_q;
    assign pair_count = r_count_q;
    // Derived from registered state only, so it clears with the async reset.
    assign out_last   = r_valid_q && (r_count_q == c_LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_fifo_pair_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_pair_reader
//  Description : Self-checking bench for fifo_pair_reader. A queue models the
//                show-ahead FIFO; a reference model groups popped words into
//                pairs and frame indices, and a monitor compares each
//                accepted pair against the expected queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pair_reader;

    localparam int DATA_WIDTH  = 8;
    localparam int FRAME_PAIRS = 16;
    localparam int CNT_WIDTH   = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  fifo_empty = 1'b1;
    logic [DATA_WIDTH-1:0] fifo_data = '0;
    logic                  out_ready = 1'b0;
    logic                  fifo_re;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  out_last;
    logic [CNT_WIDTH-1:0]  pair_count;

    fifo_pair_reader #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAME_PAIRS(FRAME_PAIRS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_re   (fifo_re),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  last;
    } pair_t;

    logic [DATA_WIDTH-1:0] fq[$];     // FIFO contents, head at index 0
    logic [DATA_WIDTH-1:0] part[$];   // words popped toward the next pair
    pair_t                 sb[$];     // expected pairs awaiting handshake
    int                    idx = 0;   // expected frame index
    int                    total = 0;
    int                    bad = 0;
    logic                  re_s;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    endtask

    task automatic push(input logic [DATA_WIDTH-1:0] w);
        fq.push_back(w);
        upd();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // FIFO pop: the pop decision is sampled mid-cycle and applied after the edge.
    initial forever begin
        @(negedge clk);
        re_s = fifo_re;
        @(posedge clk);
        #1;
        if (re_s && fq.size() != 0) void'(fq.pop_front());
        upd();
    end

    // Monitor + reference model, evaluated mid-cycle for the coming edge.
    initial forever begin
        logic  exp_re;
        pair_t e;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_fifo_re", {31'd0, fifo_re}, 0);
            check("rst_out_valid", {31'd0, out_valid}, 0);
            check("rst_out_last", {31'd0, out_last}, 0);
            check("rst_out_a", {24'd0, out_a}, 0);
            check("rst_out_b", {24'd0, out_b}, 0);
            check("rst_pair_count", {28'd0, pair_count}, 0);
            sb.delete();
            part.delete();
            idx = 0;
        end else begin
            exp_re = !flush && (fq.size() != 0) && (sb.size() == 0 || out_ready);
            check("fifo_re", {31'd0, fifo_re}, {31'd0, exp_re});
            check("out_valid", {31'd0, out_valid}, (sb.size() != 0) ? 1 : 0);
            check("pair_count", {28'd0, pair_count}, idx);
            if (!out_valid) check("out_last_idle", {31'd0, out_last}, 0);
            if (flush) begin
                sb.delete();
                part.delete();
                idx = 0;
            end else begin
                if (sb.size() != 0 && out_ready) begin
                    e = sb.pop_front();
                    check("pair_a", {24'd0, out_a}, {24'd0, e.a});
                    check("pair_b", {24'd0, out_b}, {24'd0, e.b});
                    check("pair_last", {31'd0, out_last}, {31'd0, e.last});
                    idx = (idx + 1) % FRAME_PAIRS;
                end
                if (exp_re) begin
                    part.push_back(fq[0]);
                    if (part.size() == 2) begin
                        e.a    = part[0];
                        e.b    = part[1];
                        e.last = (idx == FRAME_PAIRS - 1);
                        sb.push_back(e);
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic drain(input string nm);
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (fq.size() == 0 && !out_valid) break;
            cyc();
        end
        check(nm, {31'd0, (fq.size() == 0 && !out_valid)}, 1);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            cyc();
            n++;
        end
        check(nm, {31'd0, out_valid}, 1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    initial begin
        // Reset held with a non-empty FIFO and a ready sink.
        out_ready = 1'b1;
        for (int w = 1; w <= 32; w++) push(DATA_WIDTH'(w));
        repeat (4) cyc();
        rst_n = 1'b1;
        drain("stream_drain");

        // Backpressure while holding a pair.
        out_ready = 1'b0;
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        wait_valid("bp_valid");
        repeat (5) cyc();
        drain("bp_drain");

        // FIFO starves between a and b.
        push(8'hAA);
        repeat (4) cyc();
        push(8'hBB);
        drain("starve_drain");

        // Flush in GET_B, then flush in HOLD together with out_ready.
        push(8'h11);
        cyc();
        cyc();
        do_flush();
        push(8'h21); push(8'h22);
        drain("flush_getb_drain");
        out_ready = 1'b0;
        push(8'h31); push(8'h32);
        wait_valid("flush_hold_valid");
        out_ready = 1'b1;
        do_flush();
        drain("flush_hold_drain");

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2) == 0) push(DATA_WIDTH'($urandom));
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(39) == 0);
            cyc();
        end
        flush = 1'b0;
        do_flush();
        drain("rand_drain");

        // Reach pair 7 in HOLD, then assert reset between clock edges.
        for (int i = 0; i < 300; i++) begin
            if (pair_count == 4'd7 && out_valid) break;
            if (fq.size() < 4) push(DATA_WIDTH'($urandom));
            out_ready = (pair_count != 4'd7);
            cyc();
        end
        check("pre_rst_hold", {31'd0, (out_valid && pair_count == 4'd7)}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 0);
        check("async_out_last", {31'd0, out_last}, 0);
        check("async_pair_count", {28'd0, pair_count}, 0);
        check("async_fifo_re", {31'd0, fifo_re}, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        drain("post_rst_drain");
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_pair_reader.md
# fifo_pair_reader

Read-side companion to the team's synchronous FIFO. It drains show-ahead FIFO words and packs consecutive words into (a, b) operand pairs for the butterfly stage. Pairs are presented on a valid/ready handshake and grouped into frames of FRAME_PAIRS pairs, with a last-pair marker. It sits between the input FIFO and the butterfly compute unit.

## Interface
- DATA_WIDTH, 8, width of one FIFO word and of each operand
- FRAME_PAIRS, 16, pairs per frame (must be ≥1 and ≤ 2^CNT_WIDTH)
- CNT_WIDTH, 4, width of pair_count
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- flush  input  1  synchronous abort of the current pair and frame
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  DATA_WIDTH  FIFO head word, valid in the same cycle whenever fifo_empty=0 (show-ahead)
- fifo_re  output  1  FIFO read enable; pops the head word at the rising edge
- out_valid  output  1  pair available on out_a/out_b
- out_ready  input  1  downstream accepts the pair
- out_a  output  DATA_WIDTH  first word of the pair (older word)
- out_b  output  DATA_WIDTH  second word of the pair
- out_last  output  1  current pair is the last pair of the frame
- pair_count  output  CNT_WIDTH  index within the frame of the pair being fetched or held

## Operation
- FSM states:
  - GET_A (reset state)
  - GET_B
  - HOLD
- fifo_re is combinational: rst_n && !flush && !fifo_empty && (state==GET_A || state==GET_B || (state==HOLD && out_ready)).
- fifo_re is never high while fifo_empty=1.
- GET_A:
  - If !fifo_empty: out_a <= fifo_data, go to GET_B.
  - Otherwise stay in GET_A.
- GET_B:
  - If !fifo_empty: out_b <= fifo_data, out_valid <= 1, go to HOLD.
  - Otherwise stay in GET_B; out_a is held.
- HOLD:
  - out_valid=1.
  - out_a, out_b and out_last are stable until the handshake completes.
- Handshake completes when out_valid && out_ready:
  - pair_count increments, wrapping to 0 after FRAME_PAIRS-1.
  - If !fifo_empty in the same cycle: out_a <= fifo_data, out_valid <= 0, go to GET_B (back-to-back fetch).
  - Otherwise: out_valid <= 0, go to GET_A.
- out_last = out_valid && (pair_count == FRAME_PAIRS-1).
- flush (highest priority after reset):
  - Next state GET_A; out_valid <= 0; pair_count <= 0.
  - out_a/out_b keep their values, which are don't-care.
  - No FIFO pop occurs in the flush cycle.
  - A held or partial pair is discarded, and the downstream does not see a handshake.
- Reset (async assert, any state): state=GET_A, out_valid=0, out_last=0, out_a=0, out_b=0, pair_count=0, fifo_re=0.
- Reset release is synchronous to clk. The first pop can occur in the first cycle after deassertion.

## Timing
- Latency: the first word is popped at edge N; the second at edge N+1 if available; out_valid=1 after edge N+1.
- Steady-state throughput with FIFO non-empty and out_ready=1: one pair per 2 cycles (GET_B → HOLD → GET_B ...).
- With out_ready=0: HOLD persists indefinitely with no FIFO pops and all outputs constant.
- FIFO goes empty between a and b: stall in GET_B and keep out_a. out_b is captured on the first cycle fifo_empty=0.
- Simultaneous flush and out_ready in HOLD: flush wins. No handshake is counted and pair_count becomes 0.
- Wrap-around: the handshake on pair FRAME_PAIRS-1 returns pair_count to 0. out_last deasserts with out_valid.

## Test plan
- Reset: hold rst_n=0 with fifo_empty=0 and out_ready=1 -> fifo_re=0, out_valid=0, out_a=out_b=0, pair_count=0; after release, the first pop occurs on the next edge.
- Streaming: FIFO preloaded with 0x01..0x20, out_ready=1 -> pairs (01,02),(03,04)…(1F,20) at one per 2 cycles; out_last high only on (1F,20); pair_count returns to 0.
- Backpressure: out_ready=0 for 5 cycles while holding (05,06) -> outputs stable, fifo_re=0 throughout; out_ready=1 -> exactly one handshake, and 0x07 is popped in the same cycle.
- Starved middle: push 0xAA, wait 4 cycles, push 0xBB -> GET_B stalls with out_a=AA and fifo_re=0 while empty; then out_valid=1 with (AA,BB).
- Flush: flush=1 while in GET_B with out_a=0x11 -> no pop that cycle, state GET_A, pair_count=0; the next two words form pair 0. Repeat flush in HOLD with out_ready=1 -> no handshake counted.
- Async reset mid-frame: assert rst_n=0 between edges at pair_count=7 in HOLD -> out_valid, out_last and pair_count go to 0 immediately, without waiting for a clock edge.
